l2_msg3_ingress_queue: RTL and testbench

//  Ingress buffer for the L2 msg3 channel: writebacks and other msg3 traffic.

---
 rtl/l2_msg3_ingress_queue.sv | 132 +++++++++++++
 tb/tb_l2_msg3_ingress_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_msg3_ingress_queue.sv
// l2_msg3_ingress_queue: in-order ingress FIFO for L2 msg3 traffic (writebacks etc.)
// with a writeback tag-hazard lookup for the msg1 path and a saturating
// count of dequeued writebacks.
// Optional feature macro: L2_MSG3_BYPASS_EN -- when the queue is empty, an
// incoming message is presented to the pipe combinationally and, if taken in
// the same cycle, never written into the FIFO.
module l2_msg3_ingress_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter logic [7:0]  WB_TYPE = 8'h0C
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       msg3_valid,
   input  logic [7:0]                 msg3_type,
   input  logic [5:0]                 msg3_source,
   input  logic [25:0]                msg3_tag,
   input  logic [63:0]                msg3_data,
   output logic                       msg3_ready,
   output logic                       pipe_valid,
   output logic [7:0]                 pipe_type,
   output logic [5:0]                 pipe_source,
   output logic [25:0]                pipe_tag,
   output logic [63:0]                pipe_data,
   output logic                       pipe_is_wb,
   input  logic                       pipe_ready,
   input  logic [25:0]                lookup_tag,
   output logic                       lookup_hit,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [15:0]                wb_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   typedef struct packed {
      logic [7:0]  typ;
      logic [5:0]  source;
      logic [25:0] tag;
      logic [63:0] data;
   } msg_t;

   msg_t             mem [DEPTH];
   logic [DEPTH-1:0] ent_vld;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ_q;
   logic [15:0]      wb_q;

   msg_t in_msg;
   msg_t head_msg;
   logic fifo_vld;
   logic push;
   logic pop_fifo;
   logic consume;
   logic hit;

   assign in_msg     = {msg3_type, msg3_source, msg3_tag, msg3_data};
   assign msg3_ready = !rst && (occ_q < FULL_OCC);
   assign fifo_vld   = !rst && (occ_q != '0);
   assign pop_fifo   = fifo_vld && pipe_ready;

`ifdef L2_MSG3_BYPASS_EN
   logic byp;
   // Empty queue: the incoming message is the head; taken same cycle means no FIFO write.
   assign byp        = !rst && (occ_q == '0) && msg3_valid;
   assign head_msg   = byp ? in_msg : mem[rd_ptr];
   assign pipe_valid = fifo_vld || byp;
   assign push       = msg3_valid && msg3_ready && !(byp && pipe_ready);
`else
   assign head_msg   = mem[rd_ptr];
   assign pipe_valid = fifo_vld;
   assign push       = msg3_valid && msg3_ready;
`endif

   assign consume     = pipe_valid && pipe_ready;
   assign pipe_type   = head_msg.typ;
   assign pipe_source = head_msg.source;
   assign pipe_tag    = head_msg.tag;
   assign pipe_data   = head_msg.data;
   assign pipe_is_wb  = (head_msg.typ == WB_TYPE);
   assign occupancy   = occ_q;
   assign wb_count    = wb_q;

   // Pointers, entry-valid bits, occupancy and writeback counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ent_vld <= '0;
         occ_q   <= '0;
         wb_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr          <= wr_ptr + PTR_W'(1);
            ent_vld[wr_ptr] <= 1'b1;
         end
         if (pop_fifo) begin
            rd_ptr          <= rd_ptr + PTR_W'(1);
            ent_vld[rd_ptr] <= 1'b0;
         end
         case ({push, pop_fifo})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
         if (consume && pipe_is_wb && (wb_q != 16'hFFFF)) begin
            wb_q <= wb_q + 16'd1;
         end
      end
   end

   // Message storage; payload needs no reset since entry-valid bits qualify it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_msg;
      end
   end

   // Writeback tag-hazard probe over all queued entries (head included until popped).
   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && (mem[i].typ == WB_TYPE) && (mem[i].tag == lookup_tag)) begin
            hit = 1'b1;
         end
      end
   end

   assign lookup_hit = hit && !rst;

endmodule

// File: tb/tb_l2_msg3_ingress_queue.sv
// Self-checking bench for l2_msg3_ingress_queue: a reference queue of accepted
// messages supplies the expected head, occupancy, hazard lookup and wb_count.
module tb_l2_msg3_ingress_queue;

   localparam int unsigned DEPTH = 4;
   localparam logic [7:0]  WB    = 8'h0C;

   typedef struct packed {
      logic [7:0]  typ;
      logic [5:0]  source;
      logic [25:0] tag;
      logic [63:0] data;
   } msg_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        msg3_valid = 1'b0;
   logic [7:0]  msg3_type = '0;
   logic [5:0]  msg3_source = '0;
   logic [25:0] msg3_tag = '0;
   logic [63:0] msg3_data = '0;
   logic        msg3_ready;
   logic        pipe_valid;
   logic [7:0]  pipe_type;
   logic [5:0]  pipe_source;
   logic [25:0] pipe_tag;
   logic [63:0] pipe_data;
   logic        pipe_is_wb;
   logic        pipe_ready = 1'b0;
   logic [25:0] lookup_tag = '0;
   logic        lookup_hit;
   logic [2:0]  occupancy;
   logic [15:0] wb_count;

   int n_chk = 0;
   int n_err = 0;

   msg_t sb[$];
   int   m_occ = 0;
   logic [15:0] m_wb = '0;

   l2_msg3_ingress_queue #(.DEPTH(DEPTH), .WB_TYPE(WB)) dut (
      .clk(clk), .rst(rst),
      .msg3_valid(msg3_valid), .msg3_type(msg3_type), .msg3_source(msg3_source),
      .msg3_tag(msg3_tag), .msg3_data(msg3_data), .msg3_ready(msg3_ready),
      .pipe_valid(pipe_valid), .pipe_type(pipe_type), .pipe_source(pipe_source),
      .pipe_tag(pipe_tag), .pipe_data(pipe_data), .pipe_is_wb(pipe_is_wb),
      .pipe_ready(pipe_ready), .lookup_tag(lookup_tag), .lookup_hit(lookup_hit),
      .occupancy(occupancy), .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   function automatic msg_t mk(input logic [7:0] t, input logic [25:0] tag);
      mk = {t, 6'(tag[5:0] ^ 6'h15), tag, {32'hC0DE_0000 | 32'(tag), 24'h0, t}};
   endfunction

   // One clock of stimulus: drive at negedge, compare outputs to the model, advance the model.
   task automatic cycle(input logic v, input msg_t m, input logic prdy);
      msg_t exp;
      logic exp_pv, exp_hit, byp, acc, pop;
      @(negedge clk);
      msg3_valid = v; msg3_type = m.typ; msg3_source = m.source;
      msg3_tag = m.tag; msg3_data = m.data; pipe_ready = prdy;
      #1;
      byp = 1'b0;
`ifdef L2_MSG3_BYPASS_EN
      byp = (m_occ == 0) && v;
`endif
      exp_pv = (m_occ != 0) || byp;
      n_chk++;
      if (msg3_ready !== (m_occ < DEPTH)) begin
         n_err++; $display("FAIL msg3_ready: got %b expected %b", msg3_ready, m_occ < DEPTH);
      end
      n_chk++;
      if (pipe_valid !== exp_pv) begin
         n_err++; $display("FAIL pipe_valid: got %b expected %b", pipe_valid, exp_pv);
      end
      if (exp_pv) begin
         exp = byp ? m : sb[0];
         n_chk++;
         if ({pipe_type, pipe_source, pipe_tag, pipe_data} !== exp) begin
            n_err++;
            $display("FAIL head: got %h/%h/%h/%h expected %h/%h/%h/%h", pipe_type, pipe_source,
                     pipe_tag, pipe_data, exp.typ, exp.source, exp.tag, exp.data);
         end
         n_chk++;
         if (pipe_is_wb !== (exp.typ == WB)) begin
            n_err++; $display("FAIL pipe_is_wb: got %b expected %b", pipe_is_wb, exp.typ == WB);
         end
      end
      n_chk++;
      if (occupancy !== 3'(m_occ)) begin
         n_err++; $display("FAIL occupancy: got %0d expected %0d", occupancy, m_occ);
      end
      exp_hit = 1'b0;
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].typ == WB && sb[i].tag == lookup_tag) exp_hit = 1'b1;
      end
      n_chk++;
      if (lookup_hit !== exp_hit) begin
         n_err++; $display("FAIL lookup_hit: got %b expected %b", lookup_hit, exp_hit);
      end
      n_chk++;
      if (wb_count !== m_wb) begin
         n_err++; $display("FAIL wb_count: got %0d expected %0d", wb_count, m_wb);
      end
      acc = v && (m_occ < DEPTH);
      pop = exp_pv && prdy;
      if (pop) begin
         exp = byp ? m : sb.pop_front();
         if (exp.typ == WB && m_wb != 16'hFFFF) m_wb = m_wb + 16'd1;
      end
      if (byp && prdy) acc = 1'b0;
      if (acc) sb.push_back(m);
      m_occ = m_occ + (acc ? 1 : 0) - ((pop && !(byp && prdy)) ? 1 : 0);
   endtask

   task automatic idle(input logic prdy);
      cycle(1'b0, '0, prdy);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_chk++;
      if (msg3_ready !== 1'b0 || pipe_valid !== 1'b0 || lookup_hit !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got rdy=%b pv=%b hit=%b expected 0/0/0",
                  msg3_ready, pipe_valid, lookup_hit);
      end
      rst = 1'b0;
      #1;
      n_chk++;
      if (occupancy !== 3'd0 || wb_count !== 16'd0 || msg3_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state: got occ=%0d wb=%0d rdy=%b expected 0/0/1",
                  occupancy, wb_count, msg3_ready);
      end
   endtask

   task automatic test_single_wb();
      msg_t m;
      m = {8'h0C, 6'h01, 26'h0000ABC, 64'hDEAD_BEEF};
      lookup_tag = 26'h0000ABC;
      cycle(1'b1, m, 1'b0);
      idle(1'b0);
      n_chk++;
      if (pipe_valid !== 1'b1 || pipe_is_wb !== 1'b1 || occupancy !== 3'd1 || lookup_hit !== 1'b1) begin
         n_err++;
         $display("FAIL single_wb: got pv=%b wb=%b occ=%0d hit=%b expected 1/1/1/1",
                  pipe_valid, pipe_is_wb, occupancy, lookup_hit);
      end
      idle(1'b1);
      idle(1'b0);
   endtask

   task automatic test_fill();
      logic [7:0] types [4] = '{8'h0C, 8'h05, 8'h0C, 8'h07};
      logic [25:0] tags [4] = '{26'h10, 26'h20, 26'h30, 26'h20};
      lookup_tag = 26'h20;
      for (int i = 0; i < 4; i++) cycle(1'b1, mk(types[i], tags[i]), 1'b0);
      cycle(1'b1, mk(8'h0C, 26'h20), 1'b0);
      n_chk++;
      if (occupancy !== 3'd4 || msg3_ready !== 1'b0) begin
         n_err++;
         $display("FAIL fill_full: got occ=%0d rdy=%b expected 4/0", occupancy, msg3_ready);
      end
      lookup_tag = 26'h30;
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
      idle(1'b0);
      n_chk++;
      if (wb_count !== 16'd3) begin
         n_err++; $display("FAIL fill_wb_count: got %0d expected 3", wb_count);
      end
   endtask

   task automatic test_back_to_back();
      lookup_tag = 26'h55;
      cycle(1'b1, mk(8'h0C, 26'h55), 1'b0);
      cycle(1'b1, mk(8'h03, 26'h56), 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, mk(((i % 3) == 0) ? WB : 8'(8'h40 + i), 26'(26'h50 + $urandom_range(0, 7))), 1'b1);
      end
      idle(1'b0);
      n_chk++;
      if (occupancy !== 3'd2) begin
         n_err++; $display("FAIL b2b_occupancy: got %0d expected 2", occupancy);
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
   endtask

   task automatic test_full_pop_push();
      for (int i = 0; i < 4; i++) cycle(1'b1, mk(8'h0C, 26'(26'h100 + i)), 1'b0);
      cycle(1'b1, mk(8'h09, 26'h1FF), 1'b1);
      idle(1'b0);
      n_chk++;
      if (occupancy !== 3'd3) begin
         n_err++; $display("FAIL full_pop_push: got occ=%0d expected 3", occupancy);
      end
   endtask

   task automatic test_mid_reset();
      lookup_tag = 26'h102;
      idle(1'b0);
      @(negedge clk);
      rst = 1'b1; msg3_valid = 1'b0; pipe_ready = 1'b0;
      #1;
      n_chk++;
      if (msg3_ready !== 1'b0 || pipe_valid !== 1'b0 || lookup_hit !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_held: got rdy=%b pv=%b hit=%b expected 0/0/0",
                  msg3_ready, pipe_valid, lookup_hit);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_chk++;
      if (pipe_valid !== 1'b0 || occupancy !== 3'd0 || lookup_hit !== 1'b0 || wb_count !== 16'd0) begin
         n_err++;
         $display("FAIL mid_reset_after: got pv=%b occ=%0d hit=%b wb=%0d expected 0/0/0/0",
                  pipe_valid, occupancy, lookup_hit, wb_count);
      end
      sb.delete();
      m_occ = 0;
      m_wb  = '0;
      idle(1'b0);
   endtask

`ifdef L2_MSG3_BYPASS_EN
   task automatic test_bypass();
      lookup_tag = 26'h777;
      cycle(1'b1, mk(8'h0C, 26'h777), 1'b1);
      idle(1'b0);
      n_chk++;
      if (occupancy !== 3'd0 || wb_count !== 16'd1) begin
         n_err++;
         $display("FAIL bypass: got occ=%0d wb=%0d expected 0/1", occupancy, wb_count);
      end
      cycle(1'b1, mk(8'h0C, 26'h778), 1'b0);
      idle(1'b1);
      idle(1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_single_wb();
      test_fill();
      test_back_to_back();
      test_full_pop_push();
      test_mid_reset();
`ifdef L2_MSG3_BYPASS_EN
      test_bypass();
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
